// File: rtl/smem_pkg.sv
// smem_pkg: shared widths, header field offsets and collector FSM states
package smem_pkg;
   localparam int READ_NUM_WIDTH = 8;
   localparam int BEAT_W = 512;
   localparam int HDR_RN_LSB = 0;
   localparam int HDR_RN_W = 10;
   localparam int HDR_MS_LSB = 64;
   localparam int HDR_MS_W = 7;
   localparam int HDR_RET_LSB = 128;
   localparam int HDR_RET_W = 7;
   typedef enum logic [2:0] {S_IDLE, S_WAIT_REQ, S_STREAM, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/smem_sync_fifo.sv
// smem_sync_fifo: single-clock beat buffer with occupancy count; a push while full succeeds only alongside a pop
module smem_sync_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic wr_ok, rd_ok;
   assign full = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   assign pop_data = mem[rp_q];
   assign rd_ok = pop && !empty;
   assign wr_ok = push && (!full || rd_ok);
   // next pointers and occupancy
   always_comb begin
      wp_d = wp_q + AW'(wr_ok);
      rp_d = rp_q + AW'(rd_ok);
      cnt_d = cnt_q + CW'(wr_ok) - CW'(rd_ok);
   end
   // pointer and count state
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         cnt_q <= cnt_d;
      end
   end
   // storage array, no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wp_q] <= push_data;
   end
endmodule

// File: rtl/smem_result_collector.sv
// smem_result_collector: buffers producer result beats, checks header sequence and streams lines to host memory
module smem_result_collector import smem_pkg::*; #(
   parameter int READ_NUM_WIDTH = smem_pkg::READ_NUM_WIDTH,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [READ_NUM_WIDTH:0]   batch_size,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic                      output_request,
   output logic                      output_permit,
   input  logic [BEAT_W-1:0]         output_data,
   input  logic                      output_valid,
   input  logic                      output_finish,
   output logic                      stall,
   output logic                      host_wr_valid,
   input  logic                      host_wr_ready,
   output logic [BEAT_W-1:0]         host_wr_data,
   output logic [ADDR_WIDTH-1:0]     host_wr_addr,
   output logic                      done,
   output logic [READ_NUM_WIDTH:0]   reads_received,
   output logic [2:0]                err
);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int RW = READ_NUM_WIDTH+1;
   localparam int LW = ADDR_WIDTH-6;
   state_e state_q, state_d;
   logic [RW-1:0] batch_q, batch_d, rr_q, rr_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [LW-1:0] line_q, line_d;
   logic [2:0] err_q, err_d;
   logic [6:0] body_q, body_d, body_len;
   logic hdr_exp_q, hdr_exp_d, permit_q, permit_d, stall_q, stall_d, done_q, done_d;
   logic push, pop, ovf, full, empty;
   logic [CW-1:0] count, cnt_nxt;
   logic [BEAT_W-1:0] head;
   logic [HDR_RN_W-1:0] hdr_rn;
   logic [HDR_MS_W-1:0] hdr_ms;
   smem_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .push_data(output_data), .pop(pop),
      .pop_data(head), .full(full), .empty(empty), .count(count)
   );
   assign push = (state_q == S_STREAM) && output_valid;
   assign pop = !empty && host_wr_ready;
   assign ovf = push && full && !pop;
   assign cnt_nxt = count + CW'(push && !ovf) - CW'(pop);
   assign hdr_rn = output_data[HDR_RN_LSB +: HDR_RN_W];
   assign hdr_ms = output_data[HDR_MS_LSB +: HDR_MS_W];
   assign body_len = 7'(hdr_ms[6:1]) + 7'(hdr_ms[0]);
   assign host_wr_valid = !empty;
   assign host_wr_data = empty ? '0 : head;
   assign host_wr_addr = base_q + {line_q, 6'b0};
   assign output_permit = permit_q;
   assign stall = stall_q;
   assign done = done_q;
   assign reads_received = rr_q;
   assign err = err_q;
   // header parsing, error tracking, line indexing and state transitions
   always_comb begin
      state_d = state_q;
      batch_d = batch_q;
      base_d = base_q;
      rr_d = rr_q;
      err_d = err_q;
      body_d = body_q;
      hdr_exp_d = hdr_exp_q;
      line_d = pop ? line_q + LW'(1) : line_q;
      if (push && hdr_exp_q) begin
         err_d[0] = err_q[0] | (hdr_rn != HDR_RN_W'(rr_q));
         rr_d = &rr_q ? rr_q : rr_q + RW'(1);
         body_d = body_len;
         hdr_exp_d = body_len == '0;
      end else if (push) begin
         body_d = body_q - 7'd1;
         hdr_exp_d = body_q == 7'd1;
      end
      err_d[1] = err_d[1] | ovf;
      if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
         state_d = S_WAIT_REQ;
         batch_d = batch_size;
         base_d = base_addr;
         rr_d = '0;
         err_d = '0;
         line_d = '0;
      end else if (state_q == S_WAIT_REQ && output_request) begin
         state_d = S_STREAM;
         hdr_exp_d = 1'b1;
         body_d = '0;
      end else if (state_q == S_STREAM && output_finish) begin
         state_d = S_DRAIN;
         err_d[2] = err_q[2] | (rr_d != batch_q);
      end else if (state_q == S_DRAIN && empty) begin
         state_d = S_DONE;
      end
      permit_d = state_d == S_STREAM || state_d == S_DRAIN;
      stall_d = state_d == S_STREAM && cnt_nxt >= CW'(FIFO_DEPTH-4);
      done_d = state_d == S_DONE;
   end
   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         batch_q <= '0;
         base_q <= '0;
         rr_q <= '0;
         err_q <= '0;
         body_q <= '0;
         hdr_exp_q <= 1'b1;
         line_q <= '0;
         permit_q <= 1'b0;
         stall_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         batch_q <= batch_d;
         base_q <= base_d;
         rr_q <= rr_d;
         err_q <= err_d;
         body_q <= body_d;
         hdr_exp_q <= hdr_exp_d;
         line_q <= line_d;
         permit_q <= permit_d;
         stall_q <= stall_d;
         done_q <= done_d;
      end
   end
endmodule

// File: tb/tb_smem_result_collector.sv
// tb_smem_result_collector: directed batches with a scoreboard of expected host line writes
module tb_smem_result_collector;
   logic clk = 1'b0;
   logic reset, start, output_request, output_permit, output_valid, output_finish, stall;
   logic host_wr_valid, host_wr_ready, done;
   logic [8:0] batch_size, reads_received;
   logic [31:0] base_addr, host_wr_addr;
   logic [511:0] output_data, host_wr_data;
   logic [2:0] err;
   typedef struct { logic [511:0] data; logic [31:0] addr; } exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0, writes = 0, exp_line = 0;
   logic [31:0] cur_base = '0;
   logic hold_v = 1'b0;
   logic [511:0] hold_d;
   logic [31:0] hold_a;

   always #5 clk = ~clk;

   smem_result_collector dut (
      .clk(clk), .reset(reset), .start(start), .batch_size(batch_size), .base_addr(base_addr),
      .output_request(output_request), .output_permit(output_permit), .output_data(output_data),
      .output_valid(output_valid), .output_finish(output_finish), .stall(stall),
      .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_data(host_wr_data),
      .host_wr_addr(host_wr_addr), .done(done), .reads_received(reads_received), .err(err)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] rnd();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [511:0] hdr(input int rn, input int ms, input int ret);
      logic [511:0] d;
      d = rnd();
      d[9:0] = rn[9:0];
      d[70:64] = ms[6:0];
      d[134:128] = ret[6:0];
      return d;
   endfunction

   task automatic sb_push(input logic [511:0] d);
      sb.push_back('{d, cur_base + 32'(64 * exp_line)});
      exp_line++;
   endtask

   task automatic begin_batch(input int bs, input logic [31:0] base);
      cur_base = base;
      exp_line = 0;
      batch_size = 9'(bs);
      base_addr = base;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("permit_wait", output_permit, 0);
      output_request = 1'b1;
      tick();
      output_request = 1'b0;
      chk("permit_stream", output_permit, 1);
   endtask

   task automatic beat(input logic [511:0] d, input logic fin, input logic store);
      output_data = d;
      output_valid = 1'b1;
      output_finish = fin;
      if (store) sb_push(d);
      tick();
      output_valid = 1'b0;
      output_finish = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && !done; i++) tick();
      chk("done", done, 1);
      chk("permit_done", output_permit, 0);
      chk("sb_empty", 512'(sb.size()), 0);
   endtask

   // host-side monitor: scoreboard compare on each transfer and hold-stability while not ready
   always @(negedge clk) begin
      if (reset) hold_v <= 1'b0;
      else begin
         if (hold_v) begin
            chk("hold_valid", host_wr_valid, 1);
            chk("hold_data", host_wr_data, hold_d);
            chk("hold_addr", host_wr_addr, hold_a);
         end
         if (host_wr_valid && host_wr_ready) begin
            writes++;
            if (sb.size() == 0) chk("unexpected_write", host_wr_valid, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("wr_data", host_wr_data, e.data);
               chk("wr_addr", host_wr_addr, e.addr);
            end
         end
         hold_v <= host_wr_valid && !host_wr_ready;
         hold_d <= host_wr_data;
         hold_a <= host_wr_addr;
      end
   end

   initial begin
      int sent, w0;
      bit s11, s12;
      logic [511:0] d;
      reset = 1'b1; start = 1'b0; batch_size = '0; base_addr = '0; output_request = 1'b0;
      output_data = '0; output_valid = 1'b0; output_finish = 1'b0; host_wr_ready = 1'b1;
      repeat (3) tick();
      chk("rst_permit", output_permit, 0);
      chk("rst_stall", stall, 0);
      chk("rst_wr_valid", host_wr_valid, 0);
      chk("rst_wr_data", host_wr_data, 0);
      chk("rst_wr_addr", host_wr_addr, 0);
      chk("rst_done", done, 0);
      chk("rst_reads", reads_received, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;
      tick();
      // basic batch, with a start pulse mid-stream that must be ignored
      begin_batch(2, 32'h0000_1000);
      beat(hdr(0, 3, 5), 1'b0, 1'b1);
      base_addr = 32'hdead_0000;
      batch_size = 9'd7;
      start = 1'b1;
      beat(rnd(), 1'b0, 1'b1);
      start = 1'b0;
      chk("done_streaming", done, 0);
      beat(rnd(), 1'b0, 1'b1);
      beat(hdr(1, 0, 0), 1'b1, 1'b1);
      wait_done();
      chk("a_reads", reads_received, 2);
      chk("a_err", err, 0);
      chk("a_writes", 512'(writes), 4);
      // header sequence error, beats still written
      begin_batch(2, 32'h0002_0000);
      beat(hdr(0, 0, 1), 1'b0, 1'b1);
      beat(hdr(2, 1, 1), 1'b0, 1'b1);
      beat(rnd(), 1'b1, 1'b1);
      wait_done();
      chk("b_reads", reads_received, 2);
      chk("b_err", err, 3'b001);
      // compliant producer obeying stall while host is not ready for 40 cycles
      host_wr_ready = 1'b0;
      begin_batch(1, 32'h0004_0000);
      sent = 0; s11 = 0; s12 = 0;
      for (int cyc = 0; cyc < 400 && sent < 20; cyc++) begin
         if (cyc == 40) host_wr_ready = 1'b1;
         if (!stall) begin
            d = (sent == 0) ? hdr(0, 38, 3) : rnd();
            output_data = d;
            output_valid = 1'b1;
            output_finish = sent == 19;
            sb_push(d);
            sent++;
         end else begin
            output_valid = 1'b0;
            output_finish = 1'b0;
         end
         tick();
         if (!host_wr_ready && sent == 11 && !s11) begin s11 = 1; chk("stall_at_11", stall, 0); end
         if (!host_wr_ready && sent == 12 && !s12) begin s12 = 1; chk("stall_at_12", stall, 1); end
      end
      output_valid = 1'b0;
      output_finish = 1'b0;
      chk("c_sent", 512'(sent), 20);
      wait_done();
      chk("c_err", err, 0);
      chk("c_reads", reads_received, 1);
      // producer ignoring stall overflows the buffer
      host_wr_ready = 1'b0;
      begin_batch(1, 32'h0008_0000);
      w0 = writes;
      for (int i = 0; i < 20; i++) beat((i == 0) ? hdr(0, 38, 2) : rnd(), i == 19, i < 16);
      tick();
      chk("d_err", err, 3'b010);
      host_wr_ready = 1'b1;
      wait_done();
      chk("d_writes", 512'(writes - w0), 16);
      // early finish leaves reads short of batch size
      begin_batch(3, 32'h0010_0000);
      beat(hdr(0, 0, 4), 1'b1, 1'b1);
      chk("e_err", err, 3'b100);
      chk("e_permit_drain", output_permit, 1);
      chk("e_done_drain", done, 0);
      wait_done();
      chk("e_reads", reads_received, 1);
      // reset mid-stream discards buffered beats
      host_wr_ready = 1'b0;
      begin_batch(4, 32'h0020_0000);
      beat(hdr(0, 8, 1), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) beat(rnd(), 1'b0, 1'b0);
      chk("f_valid_before", host_wr_valid, 1);
      reset = 1'b1;
      tick();
      chk("f_valid", host_wr_valid, 0);
      chk("f_addr", host_wr_addr, 0);
      chk("f_permit", output_permit, 0);
      chk("f_reads", reads_received, 0);
      reset = 1'b0;
      host_wr_ready = 1'b1;
      w0 = writes;
      output_request = 1'b1;
      for (int i = 0; i < 10; i++) beat(rnd(), 1'b0, 1'b0);
      output_request = 1'b0;
      chk("f_idle_permit", output_permit, 0);
      chk("f_idle_valid", host_wr_valid, 0);
      chk("f_no_writes", 512'(writes - w0), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/smem_result_collector.md
SMEM_RESULT_COLLECTOR -- requirements
Module: smem_result_collector

Interface
REQ-001 Parameters SHALL be (name, default, meaning): READ_NUM_WIDTH, 8, read-index width; FIFO_DEPTH, 16, beat buffer entries (power of 2, >=8); ADDR_WIDTH, 32, host byte-address width.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins a batch.
REQ-005 batch_size  in  READ_NUM_WIDTH+1  reads expected in the batch.
REQ-006 base_addr  in  ADDR_WIDTH  host byte address of first line, 64-byte aligned.
REQ-007 output_request  in  1  producer has results ready.
REQ-008 output_permit  out  1  grant to producer to stream.
REQ-009 output_data  in  512  result beat.
REQ-010 output_valid  in  1  output_data valid this cycle.
REQ-011 output_finish  in  1  producer has sent all reads.
REQ-012 stall  out  1  back-pressure to producer.
REQ-013 host_wr_valid / host_wr_ready  out / in  1 / 1  host write handshake.
REQ-014 host_wr_data / host_wr_addr  out / out  512 / ADDR_WIDTH  host line data and byte address.
REQ-015 done  out  1  batch fully written to host.
REQ-016 reads_received  out  READ_NUM_WIDTH+1  header beats accepted.
REQ-017 err  out  3  sticky {count_mismatch, overflow, header_seq}.

Function
REQ-018 FSM SHALL have states IDLE, WAIT_REQ, STREAM, DRAIN, DONE; IDLE->WAIT_REQ on start (latch batch_size, base_addr; clear counters, err, done); WAIT_REQ->STREAM when output_request=1; STREAM->DRAIN on output_finish=1; DRAIN->DONE when FIFO empty and no host write pending; DONE->WAIT_REQ on start.
REQ-019 start in any state other than IDLE/DONE SHALL be ignored.
REQ-020 output_permit SHALL be registered, 1 in STREAM and DRAIN only; first permit cycle is the cycle after output_request is sampled in WAIT_REQ.
REQ-021 Every output_valid=1 beat in STREAM SHALL be pushed into the FIFO unmodified; a beat with output_valid and output_finish in the same cycle SHALL be accepted before the DRAIN transition.
REQ-022 Beat parsing: first beat after entering STREAM, and first beat after a group's body, is a header: read num = data[9:0], mem_size = data[70:64], ret = data[134:128]; body length = ceil(mem_size/2) beats; mem_size=0 means next beat is a header.
REQ-023 Header read num SHALL equal reads_received; mismatch sets err[0], beat still stored; reads_received increments per header (width wraps not permitted: saturates at batch_size+1 is not required, max 2^(READ_NUM_WIDTH+1)-1).
REQ-024 stall SHALL be registered and equal 1 when FIFO occupancy >= FIFO_DEPTH-4, else 0; 0 outside STREAM.
REQ-025 Push when FIFO full and no pop same cycle SHALL drop the beat and set err[1]; push and pop in the same cycle when full SHALL succeed.
REQ-026 Host side: host_wr_valid=1 whenever FIFO non-empty; host_wr_data = FIFO head; host_wr_addr = base_addr + 64*line_index; valid/data/addr SHALL stay stable until host_wr_ready; line_index increments on each transfer.
REQ-027 On STREAM->DRAIN, if reads_received != batch_size set err[2].
REQ-028 output_valid outside STREAM SHALL be ignored and not stored.
REQ-029 done SHALL be 1 exactly in DONE; latency DRAIN->DONE is one cycle after last host transfer.

Reset
REQ-030 reset SHALL force IDLE and output_permit=0, stall=0, host_wr_valid=0, host_wr_data=0, host_wr_addr=0, done=0, reads_received=0, err=0, FIFO empty, line_index=0.
REQ-031 reset mid-batch SHALL abandon any pending host write and discard FIFO contents; no beat is written after reset deasserts until a new start.

Structure
REQ-032 smem_pkg SHALL hold READ_NUM_WIDTH, header field offsets (read num, mem_size, ret), beat width 512, FSM state enum.
REQ-033 FIFO SHALL be a separate sub-module smem_sync_fifo (width 512, depth FIFO_DEPTH, count output); parser, FSM and host address logic stay in smem_result_collector.

Verification
REQ-034 batch_size=2; reads 0 (mem_size=3, ret=5) and 1 (mem_size=0); host_wr_ready=1 -> 4 host lines at base, +64, +128, +192; reads_received=2; done=1; err=0.
REQ-035 Header read nums 0 then 2, batch_size=2 -> err[0]=1, all beats still written.
REQ-036 host_wr_ready=0 for 40 cycles during stream of 20 beats -> stall=1 at occupancy 12; no drop with compliant producer; lines written in order after ready=1.
REQ-037 Producer ignores stall, pushes 20 beats with ready=0 -> err[1]=1, exactly 16 lines written.
REQ-038 output_finish after 1 header with batch_size=3 -> err[2]=1, DRAIN then DONE.
REQ-039 reset asserted mid-STREAM with FIFO holding 5 beats -> next cycle host_wr_valid=0, state IDLE, no writes until start.
